// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART receiver.
// The optional parity check is enabled by defining UART_RX_PARITY_CHK_EN.
package uart_pkg;

  // Receiver FSM states. PARITY is visited only when the parity check is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // Serial line levels.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Width of the per-bit clock counter; sized for CLK_DIV up to 65535.
  localparam int CNT_W = 16;

  // Width of the data bit index; holds 0..7.
  localparam int IDX_W = 3;

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its environment.
// slave: the receiver side (consumes the serial line, produces the data word).
// master: the environment side (drives the line, observes results).
// Handshake: none. dout_vld is a one-cycle strobe with no ready; when it is high
// dout holds the new word for at least that cycle, and a strobe that is not
// consumed is simply lost. frame_err/parity_err are one-cycle strobes too.
interface uart_rx_if #(
  parameter int DO_WIDTH = 8
);

  logic                  uart_rx;
  logic [DO_WIDTH-1:0]   dout;
  logic                  dout_vld;
  logic                  frame_err;
  logic                  parity_err;
  logic                  busy;
  uart_pkg::uart_state_e state_dbg;

  modport slave (
    input  uart_rx,
    output dout,
    output dout_vld,
    output frame_err,
    output parity_err,
    output busy,
    output state_dbg
  );

  modport master (
    output uart_rx,
    input  dout,
    input  dout_vld,
    input  frame_err,
    input  parity_err,
    input  busy,
    input  state_dbg
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge
// detection on the synchronized value. All flops reset to the idle level so
// that reset never looks like a start edge on its own.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);
  import uart_pkg::*;

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and one extra stage of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_LVL;
      sync_q <= IDLE_LVL;
      prev_q <= IDLE_LVL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit glitch reject, LSB-first data, optional even parity,
// stop-bit framing check and a BREAK state that waits for the line to recover.
// Optional feature macro: UART_RX_PARITY_CHK_EN (one even-parity bit after data).
// Without it the frame is start + DO_WIDTH data + stop and parity_err stays 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int DO_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  // Start bit is sampled half a bit in; every later bit one full bit later,
  // which lands each sample near the middle of its bit.
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DO_WIDTH - 1);

  logic line_sync;
  logic line_fall;

  uart_state_e          state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [DO_WIDTH-1:0]  shift_q,  shift_d;
  logic [DO_WIDTH-1:0]  dout_q,   dout_d;
  logic                 vld_q,    vld_d;
  logic                 ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_CHK_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q,    perr_d;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.uart_rx),
    .dout  (line_sync),
    .fall  (line_fall)
  );

  // Next-state, bit counter, shift register and output strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_CHK_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (line_fall) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          // A line that is back high mid start bit was a glitch.
          state_d = (line_sync == START_BIT) ? DATA : IDLE;
        end
      end

      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {line_sync, shift_q[DO_WIDTH-1:1]};
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_CHK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_CHK_EN
      PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          // Even parity: the parity bit must equal the XOR of the data bits.
          par_bad_d = line_sync ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (line_sync == STOP_BIT) begin
            dout_d  = shift_q;
            vld_d   = 1'b1;
`ifdef UART_RX_PARITY_CHK_EN
            perr_d  = par_bad_q;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        // Stay here until the line recovers so a long low is not taken as a start.
        if (line_sync == IDLE_LVL) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_CHK_EN
  // Parity verdict of the current frame and its output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter DO_WIDTH, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port dout  output  DO_WIDTH  last correctly received data word.
REQ-007 SHALL have port dout_vld  output  1  one-cycle pulse when dout updates.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass uart_rx through a 2-flop synchronizer (flops reset to 1) before any use; a falling edge is detected on the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 SHALL, in IDLE, enter START on a detected falling edge and clear the 16-bit bit counter.
REQ-014 SHALL sample the start bit when the counter reaches CLK_DIV/2-1 (integer division); if sampled 1, return to IDLE (glitch reject) with no output pulse.
REQ-015 SHALL then sample each later bit when the counter reaches CLK_DIV-1, clearing the counter at every sample.
REQ-016 SHALL shift in DO_WIDTH data bits LSB first in DATA, counting them with a bit index that wraps back to 0 on leaving DATA.
REQ-017 SHALL, in STOP, on a sample of 1: load dout with the shifted word and pulse dout_vld on the next cycle, then go to IDLE.
REQ-018 SHALL, in STOP, on a sample of 0: pulse frame_err, leave dout unchanged, and go to BREAK, which returns to IDLE only once the synchronized line reads 1.
REQ-019 SHALL, on a parity mismatch with a valid stop bit, pulse parity_err in the same cycle as dout_vld and still update dout.
REQ-020 SHALL provide no backpressure: each frame overwrites dout; a dout_vld not consumed is lost.
REQ-021 SHALL accept a new start edge in the first cycle of IDLE following STOP, so back-to-back frames are received.
REQ-022 SHALL hold dout_vld, frame_err and parity_err low in every cycle not named above.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-frame, immediately force FSM=IDLE, counter=0, dout=0, dout_vld=0, frame_err=0, parity_err=0, busy=0, synchronizer=1.
REQ-024 SHALL, after rst_n deasserts with the line low, not start a frame until a falling edge is seen.

Configuration
REQ-025 SHALL, with macro UART_RX_PARITY_CHK_EN defined, expect one even-parity bit after the data bits (PARITY state used) and drive parity_err per REQ-019.
REQ-026 SHALL, without UART_RX_PARITY_CHK_EN, skip PARITY (DATA goes directly to STOP), expect a 1+DO_WIDTH+1 bit frame, and tie parity_err to 0.

Structure
REQ-027 SHALL place the FSM state enum typedef and the line-level constants START_BIT=0, STOP_BIT=1, IDLE_LVL=1 in shared package uart_pkg.
REQ-028 SHALL implement the synchronizer plus falling-edge detect as sub-module uart_rx_sync (parameter-free, ports clk, rst_n, din, dout, fall).

Verification
REQ-029 SHALL cover: CLK_DIV=16, no parity, frame for 0xA5 -> dout=0xA5, one-cycle dout_vld 152..160 clk after the line falling edge, frame_err=0.
REQ-030 SHALL cover: 4-cycle low glitch on an idle line -> no dout_vld, busy back to 0 by clk 12.
REQ-031 SHALL cover: frame 0x3C with stop bit 0, line held low 40 clk -> frame_err pulse, dout unchanged, busy stays 1 until the line returns high.
REQ-032 SHALL cover: UART_RX_PARITY_CHK_EN, 0x01 sent with parity bit 0 -> dout=0x01, dout_vld and parity_err pulse together; with parity bit 1 -> parity_err=0.
REQ-033 SHALL cover: back-to-back 0x00 then 0xFF with no idle gap -> two dout_vld pulses, 0x00 then 0xFF.
REQ-034 SHALL cover: rst_n low for 3 clk mid-DATA of 0x55 -> all outputs 0 and busy=0 immediately; the next clean frame 0x81 is received correctly.
